// File: rtl/acc_mem_arb_pkg.sv
// acc_mem_arb_pkg: shared state encoding and line geometry for the accelerator memory arbiter
package acc_mem_arb_pkg;
  localparam int LINE_WORDS = 16;
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  typedef enum logic [2:0] {IDLE, RD_BURST, RD_VALID, WR, WR_DONE} arb_state_t;
endpackage

// File: rtl/acc_line_buffer.sv
// acc_line_buffer: line register assembled one word at a time, cleared by reset
module acc_line_buffer
  import acc_mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic [WORD_SIZE-1:0]              wr_data,
  output logic [LINE_WORDS*WORD_SIZE-1:0]   line
);
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] words_q, words_d;
  always_comb begin
    words_d = words_q;
    if (wr_en) words_d[wr_idx] = wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) words_q <= '0;
    else words_q <= words_d;
  end
  assign line = words_q;
endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: shares one word-wide memory port, CPU first, accelerator in CPU-idle cycles
module acc_mem_arbiter
  import acc_mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE   = 16,
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = LINE_WORDS * WORD_SIZE,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic                 cpu_mem_rd_en,
  input  logic                 cpu_mem_wr_en,
  input  logic [WORD_SIZE-1:0] cpu_mem_wr_data,
  output logic [WORD_SIZE-1:0] cpu_mem_rd_data,
  input  logic                 acc_rd_en,
  input  logic [ADDR_SIZE-1:0] acc_rd_addr,
  output logic [LINE_SIZE-1:0] acc_rd_data,
  output logic                 acc_rd_data_valid,
  input  logic                 acc_wr_en,
  input  logic [ADDR_SIZE-1:0] acc_wr_addr,
  input  logic [WORD_SIZE-1:0] acc_wr_data,
  output logic                 acc_wr_done,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [WORD_SIZE-1:0] mem_wr_data,
  input  logic [WORD_SIZE-1:0] mem_rd_data
);
  arb_state_t state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, returned_q, returned_d;
  logic pend_q, pend_d;
  logic [ADDR_SIZE-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
  logic cpu_busy, start_rd, start_wr, issue_rd, issue_wr;
  logic [ADDR_SIZE-1:0] rd_addr;
  assign cpu_busy = cpu_mem_rd_en | cpu_mem_wr_en;
  assign cpu_mem_rd_data = mem_rd_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = acc_rd_en ? RD_BURST : acc_wr_en ? WR : IDLE;
      RD_BURST: state_d = (returned_d == CNT_W'(LINE_WORDS)) ? RD_VALID : RD_BURST;
      WR:       state_d = cpu_busy ? WR : WR_DONE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    acc_rd_data_valid = state_q == RD_VALID;
    acc_wr_done       = state_q == WR_DONE;
  end
  always_comb begin
    start_rd   = state_q == IDLE && acc_rd_en;
    start_wr   = state_q == IDLE && !acc_rd_en && acc_wr_en;
    issue_rd   = state_q == RD_BURST && !cpu_busy && issued_q < CNT_W'(LINE_WORDS);
    issue_wr   = state_q == WR && !cpu_busy;
    rd_addr    = base_q + ADDR_SIZE'(ADDR_STRIDE) * ADDR_SIZE'(issued_q);
    issued_d   = start_rd ? '0 : issued_q + CNT_W'(issue_rd);
    returned_d = start_rd ? '0 : returned_q + CNT_W'(pend_q);
    pend_d     = issue_rd;
    base_d     = start_rd ? acc_rd_addr : base_q;
    wr_addr_d  = start_wr ? acc_wr_addr : wr_addr_q;
    wr_data_d  = start_wr ? acc_wr_data : wr_data_q;
  end
  // CPU owns the port whenever it is busy; the accelerator only fills idle cycles
  always_comb begin
    mem_addr    = cpu_busy ? cpu_mem_addr : issue_rd ? rd_addr : issue_wr ? wr_addr_q : '0;
    mem_rd_en   = cpu_busy ? cpu_mem_rd_en : issue_rd;
    mem_wr_en   = cpu_busy ? cpu_mem_wr_en : issue_wr;
    mem_wr_data = cpu_busy ? cpu_mem_wr_data : issue_wr ? wr_data_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q   <= '0;
      returned_q <= '0;
      pend_q     <= 1'b0;
      base_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      issued_q   <= issued_d;
      returned_q <= returned_d;
      pend_q     <= pend_d;
      base_q     <= base_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end
  acc_line_buffer #(.WORD_SIZE(WORD_SIZE)) u_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pend_q),
    .wr_idx  (returned_q[IDX_W-1:0]),
    .wr_data (mem_rd_data),
    .line    (acc_rd_data)
  );
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb_acc_mem_arbiter: random CPU traffic against accelerator line reads and writes, checked by a cycle-count model
module tb_acc_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cpu_mem_addr;
  logic cpu_mem_rd_en, cpu_mem_wr_en;
  logic [31:0] cpu_mem_wr_data, cpu_mem_rd_data;
  logic acc_rd_en;
  logic [15:0] acc_rd_addr;
  logic [511:0] acc_rd_data;
  logic acc_rd_data_valid;
  logic acc_wr_en;
  logic [15:0] acc_wr_addr;
  logic [31:0] acc_wr_data;
  logic acc_wr_done;
  logic [15:0] mem_addr;
  logic mem_rd_en, mem_wr_en;
  logic [31:0] mem_wr_data, mem_rd_data;
  always #5 clk = ~clk;
  acc_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_rd_en(cpu_mem_rd_en), .cpu_mem_wr_en(cpu_mem_wr_en),
    .cpu_mem_wr_data(cpu_mem_wr_data), .cpu_mem_rd_data(cpu_mem_rd_data),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .acc_rd_data_valid(acc_rd_data_valid),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data), .acc_wr_done(acc_wr_done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );
  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) - 32'h1000;
  endfunction
  logic [31:0] ram [0:65535];
  logic [31:0] ram_q;
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
      if (mem_rd_en) ram_q <= ram[mem_addr];
    end
  end
  assign mem_rd_data = ram_q;
  logic [31:0] ref_mem [0:65535];
  logic cur_rd = 1'b0, prev_rd = 1'b0;
  logic [31:0] cur_exp = '0, prev_exp = '0;
  int errs = 0, checks = 0;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_drive(input logic b, input int wmode);
    logic wr;
    logic [15:0] a;
    prev_rd = cur_rd;
    prev_exp = cur_exp;
    cur_rd = 1'b0;
    cpu_mem_rd_en = 1'b0;
    cpu_mem_wr_en = 1'b0;
    cpu_mem_addr = '0;
    cpu_mem_wr_data = '0;
    if (b) begin
      wr = wmode == 1 ? 1'b1 : wmode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      a = {8'hC0, 8'($urandom)};
      cpu_mem_addr = a;
      if (wr) begin
        cpu_mem_wr_en = 1'b1;
        cpu_mem_wr_data = $urandom;
        ref_mem[a] = cpu_mem_wr_data;
      end else begin
        cpu_mem_rd_en = 1'b1;
        cur_rd = 1'b1;
        cur_exp = ref_mem[a];
      end
    end
  endtask
  task automatic cpu_check;
    if (prev_rd) check("cpu_rd_data", cpu_mem_rd_data, prev_exp);
  endtask
  // valid lands two cycles after the 16th CPU-idle cycle counted from the cycle after the request
  task automatic run_read(input logic [15:0] base, input logic [63:0] busy, input int wmode);
    int n = 0, ev = -1, seen = -1, pulses = 0, wd = 0;
    logic [511:0] el;
    busy[63:40] = '0;
    for (int t = 1; t < 64; t++)
      if (ev < 0 && !busy[t]) begin
        n++;
        if (n == 16) ev = t + 2;
      end
    for (int t = ev - 2; t < 64; t++) busy[t] = 1'b0;
    for (int k = 0; k < 16; k++) el[32*k +: 32] = ref_mem[16'(base + 16'(k))];
    acc_rd_en = 1'b1;
    acc_rd_addr = base;
    for (int c = 0; c <= ev; c++) begin
      if (c > 0) acc_rd_addr = 16'($urandom);
      cpu_drive(busy[c], wmode);
      @(negedge clk);
      cpu_check();
      if (acc_rd_data_valid) begin
        pulses++;
        if (seen < 0) seen = c;
      end
      if (acc_wr_done) wd++;
      step();
    end
    acc_rd_en = 1'b0;
    cpu_drive(1'b0, 0);
    check("rd_valid_cycle", seen, ev);
    check("rd_pulses", pulses, 1);
    check("rd_valid_width", acc_rd_data_valid, 0);
    check("rd_line", acc_rd_data, el);
    check("rd_no_wr_done", wd, 0);
  endtask
  task automatic run_write(input logic [15:0] a, input logic [31:0] d, input logic [63:0] busy, input int wmode);
    int ed = -1, seen = -1, pulses = 0;
    busy[63:40] = '0;
    for (int t = 1; t < 64; t++) if (ed < 0 && !busy[t]) ed = t + 1;
    for (int t = ed - 1; t < 64; t++) busy[t] = 1'b0;
    acc_wr_en = 1'b1;
    acc_wr_addr = a;
    acc_wr_data = d;
    for (int c = 0; c <= ed; c++) begin
      if (c > 0) begin
        acc_wr_addr = 16'($urandom);
        acc_wr_data = $urandom;
      end
      cpu_drive(busy[c], wmode);
      @(negedge clk);
      cpu_check();
      if (acc_wr_done) begin
        pulses++;
        if (seen < 0) seen = c;
      end
      step();
    end
    acc_wr_en = 1'b0;
    cpu_drive(1'b0, 0);
    ref_mem[a] = d;
    check("wr_done_cycle", seen, ed);
    check("wr_pulses", pulses, 1);
    check("wr_done_width", acc_wr_done, 0);
    check("wr_mem", ram[a], d);
  endtask
  function automatic logic [63:0] sparse_mask();
    return {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
  endfunction
  initial begin
    int v, mism;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    cpu_drive(1'b0, 0);
    acc_rd_en = 1'b0;
    acc_rd_addr = '0;
    acc_wr_en = 1'b0;
    acc_wr_addr = '0;
    acc_wr_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_rd_data", acc_rd_data, 0);
    check("rst_valid", acc_rd_data_valid, 0);
    check("rst_wr_done", acc_wr_done, 0);
    check("rst_mem_port", {mem_addr, mem_rd_en, mem_wr_en, mem_wr_data}, 0);
    run_read(16'h1000, '0, 0);
    check("line_word0", acc_rd_data[31:0], 32'h1000_0000);
    check("line_word15", acc_rd_data[511:480], 32'h1000_000F);
    run_read(16'h2000, 64'h0418, 2);
    for (int i = 0; i < 8; i++) run_write(16'h5008 + 16'(32 * i), $urandom, '0, 0);
    run_write(16'h6000, 32'hCAFE_F00D, 64'h2, 1);
    acc_wr_en = 1'b1;
    acc_wr_addr = 16'h6100;
    acc_wr_data = 32'h1234_5678;
    run_read(16'h3000, '0, 0);
    run_write(16'h6100, 32'h1234_5678, '0, 0);
    acc_rd_en = 1'b1;
    acc_rd_addr = 16'h4000;
    repeat (8) step();
    rst_n = 1'b0;
    acc_rd_en = 1'b0;
    #1;
    check("midrst_rd_data", acc_rd_data, 0);
    check("midrst_valid", acc_rd_data_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    v = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (acc_rd_data_valid) v++;
      step();
    end
    check("midrst_no_valid", v, 0);
    check("midrst_line_cleared", acc_rd_data, 0);
    run_read(16'h4000, '0, 0);
    run_read(16'hFFF8, sparse_mask(), 0);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) run_read(16'($urandom_range(0, 16'hBFF0)), sparse_mask(), 0);
      else run_write({2'b01, 14'($urandom)}, $urandom, sparse_mask(), 0);
    end
    mism = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("mem_final", mism, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
endmodule
